// File: rtl/loader_write_queue.sv
// Loader-to-SDRAM write queue: buffers iNES loader byte writes and issues one per memory slot.
// Optional LOADER_QUEUE_CHECKSUM_EN adds a running 16-bit sum of accepted bytes.
module loader_write_queue #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_write,
    input  logic [21:0]           in_addr,
    input  logic [7:0]            in_data,
    input  logic                  slot,
    input  logic                  flush,
    output logic                  out_write,
    output logic [21:0]           out_addr,
    output logic [7:0]            out_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
`ifdef LOADER_QUEUE_CHECKSUM_EN
    output logic [15:0]           checksum,
`endif
    output logic                  overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic            q_empty, full, pop, push, drop;

    // Queue state as of the start of the cycle; a same-cycle push never feeds the pop.
    always_comb begin
        q_empty = (wr_ptr == rd_ptr);
        full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
        pop     = slot && !q_empty;
        push    = in_write && (!full || pop);
        drop    = in_write && full && !pop;
        wr_nxt  = push ? wr_ptr + PW'(1) : wr_ptr;
        rd_nxt  = pop  ? rd_ptr + PW'(1) : rd_ptr;
        head    = mem[rd_ptr[PW-2:0]];
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr[PW-2:0]] <= '{addr: in_addr, data: in_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            out_write <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            out_write <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            level  <= wr_nxt - rd_nxt;
            empty  <= (wr_nxt == rd_nxt);
            if (drop)
                overflow <= 1'b1;
            // Outputs only move on slot cycles so each request spans a full slot.
            if (slot) begin
                out_write <= pop;
                if (pop) begin
                    out_addr <= head.addr;
                    out_data <= head.data;
                end
            end
        end
    end

`ifdef LOADER_QUEUE_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            checksum <= '0;
        else if (flush)
            checksum <= '0;
        else if (push)
            checksum <= checksum + {8'h00, in_data};
    end
`endif

endmodule

// File: tb/tb_loader_write_queue.sv
// Scoreboard bench for loader_write_queue: a reference queue model predicts every issue,
// level, empty and overflow value cycle by cycle.
module tb_loader_write_queue;
    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_write = 1'b0;
    logic [21:0] in_addr = '0;
    logic [7:0]  in_data = '0;
    logic        slot = 1'b0;
    logic        flush = 1'b0;
    logic        out_write;
    logic [21:0] out_addr;
    logic [7:0]  out_data;
    logic [DL:0] level;
    logic        empty;
    logic        overflow;
`ifdef LOADER_QUEUE_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    loader_write_queue #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset_n(reset_n), .in_write(in_write), .in_addr(in_addr),
        .in_data(in_data), .slot(slot), .flush(flush), .out_write(out_write),
        .out_addr(out_addr), .out_data(out_data), .level(level), .empty(empty),
`ifdef LOADER_QUEUE_CHECKSUM_EN
        .checksum(checksum),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [29:0] sb [$];
    logic        m_ow = 1'b0;
    logic [21:0] m_addr = '0;
    logic [7:0]  m_data = '0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_sum = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("out_write", 32'(out_write), 32'(m_ow));
        chk("out_addr",  32'(out_addr),  32'(m_addr));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("level",     32'(level),     32'(sb.size()));
        chk("empty",     32'(empty),     32'(sb.size() == 0));
        chk("overflow",  32'(overflow),  32'(m_ovf));
`ifdef LOADER_QUEUE_CHECKSUM_EN
        chk("checksum",  32'(checksum),  32'(m_sum));
`endif
    endtask

    task automatic step(input bit w, input logic [21:0] a, input logic [7:0] d,
                        input bit s, input bit f);
        logic [29:0] e;
        bit          popped;
        @(negedge clk);
        in_write = w; in_addr = a; in_data = d; slot = s; flush = f;
        @(posedge clk);
        #1;
        if (f) begin
            sb.delete();
            m_ow = 1'b0; m_ovf = 1'b0; m_sum = '0;
        end else begin
            popped = s && (sb.size() != 0);
            if (s) begin
                m_ow = popped;
                if (popped) begin
                    e = sb.pop_front();
                    m_addr = e[29:8];
                    m_data = e[7:0];
                end
            end
            if (w) begin
                if (sb.size() < DEPTH) begin
                    sb.push_back({a, d});
                    m_sum = m_sum + {8'h00, d};
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        check_all();
        in_write = 1'b0; slot = 1'b0; flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0);
    endtask

    // Slot every 4th cycle, like nes_ce == 3.
    task automatic drain_slot();
        idle(3);
        step(0, '0, '0, 1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_write = 1'b0; slot = 1'b0; flush = 1'b0;
        reset_n = 1'b0;
        #1;
        sb.delete();
        m_ow = 1'b0; m_addr = '0; m_data = '0; m_ovf = 1'b0; m_sum = '0;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        idle(1);

        // Reset mid-burst
        for (int i = 0; i < 3; i++) step(1, 22'(i), 8'(8'hC0 + i), 0, 0);
        do_reset();
        step(0, '0, '0, 1, 0);
        chk("no_write_after_reset", 32'(out_write), 32'd0);

        // Single write
        step(1, 22'h000010, 8'hA5, 0, 0);
        idle(1);
        step(0, '0, '0, 1, 0);
        chk("single_issue", {out_write, 1'b0, out_addr, out_data}, {1'b1, 1'b0, 22'h000010, 8'hA5});
        idle(3);
        chk("single_held", 32'(out_write), 32'd1);
        step(0, '0, '0, 1, 0);
        chk("single_done", 32'(out_write), 32'd0);

        // Fill and overflow
        for (int i = 1; i <= 5; i++) step(1, 22'(i), 8'(i), 0, 0);
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_ovf", 32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            drain_slot();
            chk("fill_order", 32'(out_data), 32'(i));
        end
        drain_slot();
        chk("no_fifth", 32'(out_write), 32'd0);

        // Simultaneous full push and slot
        step(0, '0, '0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 22'(32'h100 + i), 8'(8'h10 + i), 0, 0);
        step(1, 22'h000104, 8'h14, 1, 0);
        chk("simul_ovf", 32'(overflow), 32'd0);
        chk("simul_level", 32'(level), 32'd4);
        chk("simul_first", 32'(out_data), 32'h10);
        for (int i = 1; i <= 4; i++) begin
            drain_slot();
            chk("simul_order", 32'(out_data), 32'(8'h10 + i));
        end

        // Push on slot into empty queue
        drain_slot();
        step(1, 22'h200000, 8'h7E, 1, 0);
        chk("no_bypass", 32'(out_write), 32'd0);
        drain_slot();
        chk("late_issue", {out_write, 1'b0, out_addr, out_data}, {1'b1, 1'b0, 22'h200000, 8'h7E});

        // Flush with 2 entries and overflow set
        for (int i = 0; i < 5; i++) step(1, 22'(32'h300 + i), 8'(8'h40 + i), 0, 0);
        drain_slot();
        drain_slot();
        chk("pre_flush_level", 32'(level), 32'd2);
        step(0, '0, '0, 0, 1);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_ovf", 32'(overflow), 32'd0);
        chk("flush_ow", 32'(out_write), 32'd0);
`ifdef LOADER_QUEUE_CHECKSUM_EN
        chk("flush_sum", 32'(checksum), 32'd0);
        step(1, 22'h0, 8'hFF, 0, 0);
        step(1, 22'h1, 8'h02, 0, 0);
        chk("sum_0101", 32'(checksum), 32'h0101);
`endif
        drain_slot();
        drain_slot();
        drain_slot();

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 2) != 0), 22'($urandom), 8'($urandom),
                 ((i % 4) == 3), ($urandom_range(0, 60) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/loader_write_queue.md
Name: loader_write_queue

Overview:
- Buffers ROM-image byte writes from the iNES game loader and issues them to the SDRAM controller, one write per NES memory slot.
- Upstream: game loader (mem_addr / mem_data / mem_write).
- Downstream: the sdram addr/din/we inputs while downloading.
- Replaces the single-entry loader_write_triggered latch, which silently lost bytes when two loader writes fell inside one 4-cycle slot.

Parameters:
- DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4 entries); legal range 1..4.

Ports:
- clk  in  1  system clock (NES clk domain).
- reset_n  in  1  asynchronous active-low reset.
- in_write  in  1  one-cycle write strobe from the loader.
- in_addr  in  22  SDRAM byte address (PRG at 0x000000, CHR at 0x200000).
- in_data  in  8  byte to write.
- slot  in  1  one-cycle memory-slot strobe; the top level drives it with (nes_ce == 3).
- flush  in  1  synchronous clear; the top level asserts it while loader reset is active.
- out_write  out  1  SDRAM write request; held for one full slot period.
- out_addr  out  22  SDRAM address for out_write.
- out_data  out  8  SDRAM data for out_write.
- level  out  DEPTH_LOG2+1  number of entries currently queued.
- empty  out  1  level == 0.
- overflow  out  1  sticky flag: a write was dropped because the queue was full.

Behaviour:
- Reset (reset_n low, async):
  - Pointers and level go to 0.
  - out_write=0, out_addr=0, out_data=0, overflow=0, empty=1.
- Storage: circular FIFO of 2^DEPTH_LOG2 entries, each {addr[21:0], data[7:0]}.
  - Read and write pointers are DEPTH_LOG2+1 bits wide; the extra MSB distinguishes full from empty.
  - full = pointers equal except for the MSB.
- Push:
  - On in_write with not full: store {in_addr, in_data} at the write pointer and advance it.
  - On in_write with full: drop the write and set overflow. The exception is the simultaneous-pop rule below.
- Issue: on a slot cycle, out_write <= !empty (queue state as of the start of that cycle).
  - If not empty: out_addr/out_data <= head entry, and the read pointer advances (pop).
  - If empty: out_write <= 0, and out_addr/out_data hold their previous values.
  - out_write, out_addr and out_data change only on slot cycles, so each request is stable for exactly one slot period (4 clk at nominal nes_ce).
- Same-cycle push and pop:
  - Both occur and level is unchanged.
  - A push while full is accepted when a pop happens in the same cycle; overflow is not set.
- No bypass:
  - A byte pushed on cycle N is issued at the first slot strictly after N.
  - A push on the same cycle as a slot into an empty queue is issued at the following slot.
- level and empty are registered and reflect the post-cycle pointer state.
- flush (synchronous, priority over push and pop):
  - Pointers go to 0, out_write=0, overflow=0.
  - out_addr/out_data hold their values.
- Throughput: 1 write per slot. A loader burst longer than the depth plus the drain during the burst sets overflow.
- Top level ORs overflow into loader_fail for LED indication.

Optional Feature:
- Macro LOADER_QUEUE_CHECKSUM_EN.
- When defined:
  - Extra output port checksum[15:0].
  - checksum is the mod-2^16 sum of in_data over every accepted push (dropped bytes excluded).
  - Updated the cycle after the push.
  - Cleared by reset_n and flush.
  - The OSD uses it to verify a download.
- When undefined: the port and its adder are absent; all other behaviour is identical.

Test Plan:
- Reset mid-burst: push 3 entries, pulse reset_n low between slots -> level=0, empty=1, out_write=0 immediately (async); the next slot produces no write.
- Single write: in_write with addr=0x000010, data=0xA5, then slot 2 cycles later -> out_write=1 with 0x000010/0xA5, held until the next slot, then 0; level returns to 0.
- Fill and overflow, DEPTH_LOG2=2, no slots: push 5 bytes 0x01..0x05 -> level=4, overflow=1. Then 4 slots -> outputs 0x01,0x02,0x03,0x04 in order, and 0x05 never appears.
- Simultaneous full push and slot: queue full with 0x10..0x13; push 0x14 on a slot cycle -> overflow stays 0, level stays 4; subsequent issues are 0x11,0x12,0x13,0x14.
- Push on slot into empty queue: in_write with 0x200000/0x7E coincident with slot -> out_write stays 0 that slot; issued at the next slot.
- Flush: queue holds 2 entries with overflow=1; assert flush for one cycle -> level=0, overflow=0, out_write=0. With LOADER_QUEUE_CHECKSUM_EN defined, checksum is 0 after flush; pushing 0xFF,0x02 then gives checksum=0x0101.
